imem_loader: RTL and testbench

- Write-side master for the instruction BRAM; the core only reads that memory, and this block fills it.
- Receives a framed byte stream from a byte source (UART RX or similar) using a valid/ready handshake.
- Assembles little-endian 32-bit words, writes them through the BRAM write port (w_addr/w_dat/w_enb/byte_enb), and holds the core until the image is loaded and its checksum has passed.

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_loader_word_assembler.sv | 33 +++
 rtl/imem_loader.sv | 203 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// default frame marker, write lane mask and the word-to-byte-address helper.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        LDR_IDLE  = 3'd0,
        LDR_LEN   = 3'd1,
        LDR_DATA  = 3'd2,
        LDR_CSUM  = 3'd3,
        LDR_DONE  = 3'd4,
        LDR_ERROR = 3'd5
    } ldr_state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam logic [3:0] FULL_WORD_ENB     = 4'b1111;

    function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                   input logic [15:0] word_idx);
        return base + {14'd0, word_idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word assembler shared by the length and payload phases.
// The completed word is presented combinationally alongside the 4th byte.
module imem_loader_word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  byte_idx;
    logic [23:0] shreg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx <= 2'd0;
            shreg    <= 24'd0;
        end else if (clr) begin
            byte_idx <= 2'd0;
            shreg    <= 24'd0;
        end else if (byte_vld) begin
            byte_idx <= byte_idx + 2'd1;
            shreg    <= {byte_in, shreg[23:8]};
        end
    end

    // After three bytes shreg holds {b2, b1, b0}; the live byte completes the word.
    assign word       = {byte_in, shreg};
    assign word_valid = byte_vld && (byte_idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Fills the instruction BRAM from a framed byte stream and holds the core until
// the image checksum passes. Optional inter-byte timeout: LOADER_TIMEOUT_EN.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// LDR_IDLE  | waiting for the sync byte, everything else discarded
// LDR_LEN   | collecting the 4-byte little-endian word count
// LDR_DATA  | collecting payload words, one BRAM write per completed word
// LDR_CSUM  | comparing the trailing byte with the payload byte sum
// LDR_DONE  | image valid, core released, further bytes dropped
// LDR_ERROR | load failed, core held; sync byte starts a new frame
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MAX_WORDS      = 1024,
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        reload,
    output logic [31:0] w_addr,
    output logic [31:0] w_dat,
    output logic        w_enb,
    output logic [3:0]  byte_enb,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    localparam logic [31:0] MAX_W32 = 32'(MAX_WORDS);
    localparam logic [15:0] MAX_W16 = 16'(MAX_WORDS);

    ldr_state_t  state, state_nxt;
    logic [31:0] len_q, len_nxt;
    logic [7:0]  csum_q, csum_nxt;
    logic [15:0] wl_q, wl_nxt;
    logic [31:0] w_addr_nxt, w_dat_nxt;
    logic        wr_nxt;

    logic        xfer;
    logic        is_sync;
    logic        asm_clr, asm_vld;
    logic [31:0] asm_word;
    logic        asm_word_valid;

    // Every state can take a byte; DONE/IDLE simply drop what they don't need.
    assign in_ready = 1'b1;
    assign xfer     = in_valid && in_ready;
    assign is_sync  = (in_data == SYNC_BYTE);

    imem_loader_word_assembler u_word_assembler (
        .clk        (clk),
        .rst        (rst),
        .clr        (asm_clr),
        .byte_vld   (asm_vld),
        .byte_in    (in_data),
        .word       (asm_word),
        .word_valid (asm_word_valid)
    );

`ifdef LOADER_TIMEOUT_EN
    localparam logic [31:0] TMO_LOAD = 32'(TIMEOUT_CYCLES - 1);

    logic        active;
    logic [31:0] tmo_cnt;
    logic        tmo_expired;

    assign active = (state == LDR_LEN) || (state == LDR_DATA) || (state == LDR_CSUM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= TMO_LOAD;
        end else if (xfer || !active) begin
            tmo_cnt <= TMO_LOAD;
        end else if (tmo_cnt != 32'd0) begin
            tmo_cnt <= tmo_cnt - 32'd1;
        end
    end

    assign tmo_expired = active && !xfer && (tmo_cnt == 32'd0);
`endif

    always_comb begin
        state_nxt  = state;
        len_nxt    = len_q;
        csum_nxt   = csum_q;
        wl_nxt     = wl_q;
        w_addr_nxt = w_addr;
        w_dat_nxt  = w_dat;
        wr_nxt     = 1'b0;
        asm_clr    = 1'b0;
        asm_vld    = 1'b0;

        case (state)
            LDR_IDLE: begin
                if (xfer && is_sync) begin
                    state_nxt = LDR_LEN;
                    len_nxt   = 32'd0;
                    csum_nxt  = 8'd0;
                    wl_nxt    = 16'd0;
                    asm_clr   = 1'b1;
                end
            end
            LDR_LEN: begin
                asm_vld = xfer;
                if (asm_word_valid) begin
                    len_nxt = asm_word;
                    if (asm_word > MAX_W32) begin
                        state_nxt = LDR_ERROR;
                    end else if (asm_word == 32'd0) begin
                        state_nxt = LDR_CSUM;
                    end else begin
                        state_nxt = LDR_DATA;
                    end
                end
            end
            LDR_DATA: begin
                asm_vld = xfer;
                if (xfer) begin
                    csum_nxt = csum_q + in_data;
                end
                if (asm_word_valid) begin
                    // Saturation guard keeps the address inside the image window.
                    if (wl_q < MAX_W16) begin
                        wr_nxt     = 1'b1;
                        w_addr_nxt = word_byte_addr(BASE_ADDR, wl_q);
                        w_dat_nxt  = asm_word;
                        wl_nxt     = wl_q + 16'd1;
                    end
                    if ({16'd0, wl_q} + 32'd1 >= len_q) begin
                        state_nxt = LDR_CSUM;
                    end
                end
            end
            LDR_CSUM: begin
                if (xfer) begin
                    state_nxt = (in_data == csum_q) ? LDR_DONE : LDR_ERROR;
                end
            end
            LDR_DONE: begin
                if (reload) begin
                    state_nxt = LDR_IDLE;
                end
            end
            LDR_ERROR: begin
                if (reload) begin
                    state_nxt = LDR_IDLE;
                end else if (xfer && is_sync) begin
                    state_nxt = LDR_LEN;
                    len_nxt   = 32'd0;
                    csum_nxt  = 8'd0;
                    wl_nxt    = 16'd0;
                    asm_clr   = 1'b1;
                end
            end
            default: begin
                state_nxt = LDR_IDLE;
            end
        endcase

`ifdef LOADER_TIMEOUT_EN
        // A stall never coincides with a completed word, so no write is dropped here.
        if (tmo_expired) begin
            state_nxt = LDR_ERROR;
            wr_nxt    = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= LDR_IDLE;
            len_q    <= 32'd0;
            csum_q   <= 8'd0;
            wl_q     <= 16'd0;
            w_addr   <= BASE_ADDR;
            w_dat    <= 32'd0;
            w_enb    <= 1'b0;
            byte_enb <= 4'b0000;
        end else begin
            state    <= state_nxt;
            len_q    <= len_nxt;
            csum_q   <= csum_nxt;
            wl_q     <= wl_nxt;
            w_addr   <= w_addr_nxt;
            w_dat    <= w_dat_nxt;
            w_enb    <= wr_nxt;
            byte_enb <= wr_nxt ? FULL_WORD_ENB : 4'b0000;
        end
    end

    assign done         = (state == LDR_DONE);
    assign error        = (state == LDR_ERROR);
    assign cpu_hold     = (state != LDR_DONE);
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a frame-level reference parser predicts
// BRAM writes and final status; a monitor checks every w_enb cycle.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 1024;
    localparam logic [7:0]  SYNC = 8'hA5;
    localparam int          TMO  = 16;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic [31:0] data;
    } mw_t;
    typedef mw_t mw_q_t[$];
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          at;
    } ew_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        reload;
    logic [31:0] w_addr;
    logic [31:0] w_dat;
    logic        w_enb;
    logic [3:0]  byte_enb;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    imem_loader #(
        .BASE_ADDR      (BASE),
        .MAX_WORDS      (MAXW),
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .reload       (reload),
        .w_addr       (w_addr),
        .w_dat        (w_dat),
        .w_enb        (w_enb),
        .byte_enb     (byte_enb),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  vectors     = 0;
    int  miscompares = 0;
    ew_t exp_q[$];
    int  exp_status  = 0;   // 0 busy/idle, 1 done, 2 error
    int  exp_wl      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest predicted write.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (w_enb === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write", w_addr, w_dat);
                end else begin
                    ew_t e;
                    e = exp_q.pop_front();
                    check("w_addr", w_addr, e.addr);
                    check("w_dat", w_dat, e.data);
                    check("byte_enb", {28'd0, byte_enb}, 32'hF);
                    check("w_latency", cyc, e.at);
                end
            end else if (byte_enb !== 4'b0000) begin
                check("byte_enb_idle", {28'd0, byte_enb}, 32'h0);
            end
        end
    end

    // Reference: parse the byte stream as frames. init_status 1 means the loader
    // is already DONE, so the whole stream is dropped.
    function automatic void model(input byte_q_t bs, input int init_status, input int init_wl,
                                  output mw_q_t wq, output int status, output int wl);
        int          n;
        int          i;
        int          len;
        logic [31:0] len32;
        logic [7:0]  sum;
        bit          complete;
        n      = bs.size();
        i      = 0;
        status = init_status;
        wl     = init_wl;
        wq.delete();
        while (i < n && status != 1) begin
            if (bs[i] != SYNC) begin
                i++;
                continue;
            end
            i++;
            status = 0;
            wl     = 0;
            if (i + 4 > n) break;
            len32 = {bs[i+3], bs[i+2], bs[i+1], bs[i]};
            i += 4;
            if (len32 > 32'(MAXW)) begin
                status = 2;
                continue;
            end
            len      = int'(len32);
            sum      = 8'd0;
            complete = 1'b1;
            for (int w = 0; w < len; w++) begin
                int p;
                p = i + 4 * w;
                if (p + 3 >= n) begin
                    complete = 1'b0;
                    break;
                end
                sum += bs[p] + bs[p+1] + bs[p+2] + bs[p+3];
                wq.push_back('{idx: p + 3, addr: BASE + 32'(4 * w),
                               data: {bs[p+3], bs[p+2], bs[p+1], bs[p]}});
                wl = w + 1;
            end
            if (!complete) break;
            i += 4 * len;
            if (i >= n) break;
            status = (bs[i] == sum) ? 1 : 2;
            i++;
        end
    endfunction

    task automatic send_stream(input byte_q_t bs, input bit gaps);
        mw_q_t wq;
        int    st;
        int    wl;
        model(bs, exp_status, exp_wl, wq, st, wl);
        for (int i = 0; i < bs.size(); i++) begin
            int  g;
            int  tries;
            bit  rdy;
            g = gaps ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0) : 0;
            repeat (g) begin
                @(posedge clk);
                #1;
            end
            in_data  = bs[i];
            in_valid = 1'b1;
            tries    = 0;
            forever begin
                @(negedge clk);
                rdy = in_ready;
                @(posedge clk);
                #1;
                if (rdy) break;
                tries++;
                if (tries > 20) begin
                    check("in_ready_timeout", {31'd0, rdy}, 32'd1);
                    break;
                end
            end
            in_valid = 1'b0;
            if (wq.size() > 0 && wq[0].idx == i) begin
                mw_t m;
                m = wq.pop_front();
                exp_q.push_back('{addr: m.addr, data: m.data, at: cyc});
            end
        end
        exp_status = st;
        exp_wl     = wl;
    endtask

    task automatic check_status(input string tag);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_done"}, {31'd0, done}, {31'd0, exp_status == 1});
        check({tag, "_error"}, {31'd0, error}, {31'd0, exp_status == 2});
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, exp_status != 1});
        check({tag, "_words_loaded"}, {16'd0, words_loaded}, 32'(exp_wl));
        check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        exp_status = 0;
        check("reload_done", {31'd0, done}, 32'd0);
        check("reload_error", {31'd0, error}, 32'd0);
        check("reload_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_w_enb", {31'd0, w_enb}, 32'd0);
        check("rst_w_addr", w_addr, BASE);
        check("rst_w_dat", w_dat, 32'd0);
        check("rst_byte_enb", {28'd0, byte_enb}, 32'd0);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_words_loaded", {16'd0, words_loaded}, 32'd0);
    endtask

    task automatic rand_frame();
        byte_q_t     bs;
        int          g;
        int          sel;
        logic [31:0] len;
        logic [7:0]  sum;
        logic [7:0]  b;
        g = int'($urandom_range(0, 3));
        for (int k = 0; k < g; k++) begin
            b = 8'($urandom);
            if (b == SYNC) b = 8'h00;
            bs.push_back(b);
        end
        bs.push_back(SYNC);
        sel = int'($urandom_range(0, 9));
        if (sel == 0)      len = 32'd0;
        else if (sel == 1) len = 32'(MAXW + 1) + 32'($urandom_range(0, 100));
        else               len = 32'($urandom_range(1, 6));
        for (int k = 0; k < 4; k++) begin
            bs.push_back(len[8*k +: 8]);
        end
        if (len <= 32'(MAXW)) begin
            sum = 8'd0;
            for (int k = 0; k < 4 * int'(len); k++) begin
                b = 8'($urandom);
                sum += b;
                bs.push_back(b);
            end
            bs.push_back(($urandom_range(0, 3) != 0) ? sum : sum + 8'd1);
        end
        if (exp_status == 1 || (exp_status == 2 && $urandom_range(0, 1) == 1)) begin
            pulse_reload();
        end
        send_stream(bs, 1'b1);
        check_status("rand");
    endtask

    byte_q_t frame_a;
    byte_q_t frame_bad;
    byte_q_t bs;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        frame_a  = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00,
                     8'h13, 8'h05, 8'h10, 8'h00,
                     8'h93, 8'h05, 8'h20, 8'h00, 8'hE0};
        frame_bad = frame_a;
        frame_bad[13] = 8'h67;
        #12;
        check_reset_values();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Two-word image, back-to-back bytes.
        send_stream(frame_a, 1'b0);
        check_status("frame_a");

        // Bytes in DONE are dropped, even a full frame.
        send_stream(frame_a, 1'b0);
        check_status("done_drop");

        // Wrong checksum: words still written, then error.
        pulse_reload();
        send_stream(frame_bad, 1'b0);
        check_status("bad_csum");

        // From ERROR: garbage ignored, sync restarts, empty image.
        bs = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_stream(bs, 1'b1);
        check_status("garbage_len0");

        // reload together with a sync byte in DONE: reload wins, byte dropped.
        in_data  = SYNC;
        in_valid = 1'b1;
        reload   = 1'b1;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        reload     = 1'b0;
        exp_status = 0;
        bs = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_stream(bs, 1'b0);
        check_status("reload_wins");

        // Length one past the limit.
        bs = '{8'hA5, 8'h01, 8'h04, 8'h00, 8'h00};
        send_stream(bs, 1'b0);
        check_status("len_overflow");

        // Reset in the middle of the first payload word.
        pulse_reload();
        bs = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05};
        send_stream(bs, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        exp_status = 0;
        exp_wl     = 0;
        exp_q.delete();
        send_stream(frame_a, 1'b1);
        check_status("after_reset");

        // Largest legal image reaches the top address.
        pulse_reload();
        begin
            byte_q_t    big;
            logic [7:0] s;
            logic [7:0] b;
            s = 8'd0;
            big = '{8'hA5, 8'h00, 8'h04, 8'h00, 8'h00};
            for (int k = 0; k < 4 * MAXW; k++) begin
                b = 8'($urandom);
                s += b;
                big.push_back(b);
            end
            big.push_back(s);
            send_stream(big, 1'b0);
        end
        check_status("max_len");

        for (int r = 0; r < 12; r++) begin
            rand_frame();
        end

`ifdef LOADER_TIMEOUT_EN
        if (exp_status != 0) pulse_reload();
        bs = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
        send_stream(bs, 1'b0);
        repeat (14) @(posedge clk);
        #1;
        check("tmo_early_error", {31'd0, error}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("tmo_error", {31'd0, error}, 32'd1);
        check("tmo_no_partial_write", 32'(exp_q.size()), 32'd0);
        exp_status = 2;
        exp_wl     = 0;
        send_stream(frame_a, 1'b0);
        check_status("tmo_recover");
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
